// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode field, opcodes and FSM states.
package instr_fetch_pkg;

    localparam int unsigned OPCODE_WIDTH = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 3'b000;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 3'b001;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the instruction memory from address 0 until HALT or the last
// address, presenting each word to the decoder one cycle after its read, with stall back-pressure.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH  = 10,
    localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic [PC_WIDTH-1:0]    im_addr,
    output logic                   im_rd_en,
    input  logic [INSTR_WIDTH-1:0] im_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam logic [PC_WIDTH-1:0] PcMax = {PC_WIDTH{1'b1}};

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                overrun_q, overrun_d;

    logic is_halt;
    logic halt_seen;
    logic rd_en;

    assign is_halt = (im_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH] == OP_HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = 1'b0;
        last_d    = last_q;
        overrun_d = overrun_q;
        halt_seen = 1'b0;
        rd_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    pc_d      = '0;
                    last_d    = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            StRun: begin
                halt_seen = valid_q & is_halt;
                rd_en     = ~stall & ~halt_seen & ~last_q;
                valid_d   = rd_en | (valid_q & stall);
                // The top address is read once; pc parks there instead of wrapping.
                if (rd_en) begin
                    if (pc_q == PcMax) begin
                        last_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                if (halt_seen) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                end else if (last_q & valid_q & ~stall) begin
                    overrun_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs are forced quiet while rst is high, before the synchronous reset has taken effect.
    assign im_rd_en    = rd_en & ~rst;
    assign im_addr     = rst ? '0 : pc_q;
    assign instr       = im_rdata;
    assign instr_valid = valid_q & ~is_halt & ~rst;
    assign busy        = (state_q == StRun) & ~rst;
    assign done        = (state_q == StDone) & ~rst;
    assign overrun     = overrun_q & ~rst;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle tables, directed corner cases and random programs.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int unsigned IW = OPCODE_WIDTH + 3 * 10 + 1;
    typedef logic [IW-1:0] word_t;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stall;
        logic       rd_en;
        logic [7:0] addr;
        logic       valid;
        word_t      instr;
        logic       busy;
        logic       done;
        logic       ovr;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, stall;

    logic [7:0] a_addr;
    logic       a_rd_en, a_valid, a_busy, a_done, a_overrun;
    word_t      a_rdata, a_instr;
    word_t      mem_a [256];

    logic [2:0] b_addr;
    logic       b_rd_en, b_valid, b_busy, b_done, b_overrun;
    word_t      b_rdata, b_instr;
    word_t      mem_b [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.PC_WIDTH(8), .ADDR_WIDTH(10)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .im_addr(a_addr), .im_rd_en(a_rd_en), .im_rdata(a_rdata),
        .instr(a_instr), .instr_valid(a_valid), .busy(a_busy),
        .done(a_done), .overrun(a_overrun)
    );

    instr_fetch #(.PC_WIDTH(3), .ADDR_WIDTH(10)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .im_addr(b_addr), .im_rd_en(b_rd_en), .im_rdata(b_rdata),
        .instr(b_instr), .instr_valid(b_valid), .busy(b_busy),
        .done(b_done), .overrun(b_overrun)
    );

    // Synchronous memories: data one cycle after a read, held otherwise.
    always_ff @(posedge clk) begin
        if (a_rd_en) a_rdata <= mem_a[a_addr];
        if (b_rd_en) b_rdata <= mem_b[b_addr];
    end

    function automatic word_t mk(input logic [2:0] op, input int unsigned tag);
        return {op, tag[30:0]};
    endfunction

    function automatic vec_t mkv(input logic r, input logic s, input logic st, input logic re,
                                 input logic [7:0] ad, input logic vl, input word_t in,
                                 input logic b, input logic d, input logic o);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.rd_en = re; v.addr = ad;
        v.valid = vl; v.instr = in; v.busy = b; v.done = d; v.ovr = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock, drive the inputs for the new cycle, then sample mid-cycle.
    task automatic cyc(input logic r, input logic s, input logic st);
        @(posedge clk);
        #1;
        rst   = r;
        start = s;
        stall = st;
        @(negedge clk);
    endtask

    task automatic rand_run(input int unsigned hpos);
        word_t      got[$];
        word_t      prev;
        logic       hold;
        logic       ovr;
        logic       bad;
        logic       found;
        int         nd;
        int         exp_len;
        prev = '0;
        for (int i = 0; i < 256; i++) mem_a[i] = mk(3'($urandom_range(0, 6)), $urandom);
        if (hpos < 256) mem_a[hpos] = mk(OP_HALT, $urandom);
        // Reference: the accepted stream is every word before the first HALT.
        exp_len = 256;
        found   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (!found && mem_a[i][IW-1 -: 3] == OP_HALT) begin
                exp_len = i;
                found   = 1'b1;
            end
        end
        cyc(1'b0, 1'b1, 1'b0);
        nd = 0; hold = 1'b0; ovr = 1'b0;
        for (int c = 0; c < 1500 && nd == 0; c++) begin
            cyc(1'b0, 1'b0, $urandom_range(0, 3) == 0);
            if (hold) begin
                chk("rand_hold_valid", a_valid, 1);
                chk("rand_hold_instr", a_instr, prev);
            end
            if (a_valid && !stall) got.push_back(a_instr);
            hold = a_valid & stall;
            prev = a_instr;
            if (a_done) begin
                nd++;
                ovr = a_overrun;
            end
        end
        chk("rand_done_seen", nd, 1);
        chk("rand_stream_len", got.size(), exp_len);
        bad = 1'b0;
        for (int i = 0; i < got.size() && i < exp_len; i++) if (got[i] !== mem_a[i]) bad = 1'b1;
        chk("rand_stream_data", bad, 0);
        chk("rand_overrun", ovr, exp_len == 256);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rand_after_done", a_done, 0);
        chk("rand_after_busy", a_busy, 0);
    endtask

    initial begin
        vec_t tbl [12];
        word_t w0, w1;
        int    nvalid, maxaddr, ndone;
        logic  ovr_at_done;

        rst = 1'b1; start = 1'b0; stall = 1'b0;
        for (int i = 0; i < 256; i++) mem_a[i] = mk(OP_ADD, i);
        for (int i = 0; i < 8; i++) mem_b[i] = mk(OP_ADD, i);
        mem_a[1] = mk(OP_SUB, 1);
        mem_a[2] = mk(OP_HALT, 2);
        w0 = mem_a[0];
        w1 = mem_a[1];

        //             rst   start stall  rd_en addr  valid instr busy  done  ovr
        tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, w0, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, w1, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, w1, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, w1, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, w1, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tbl[10] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        tbl[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].start, tbl[i].stall);
            chk($sformatf("tbl%0d_rd_en", i), a_rd_en, tbl[i].rd_en);
            chk($sformatf("tbl%0d_addr", i), a_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), a_done, tbl[i].done);
            chk($sformatf("tbl%0d_overrun", i), a_overrun, tbl[i].ovr);
            if (tbl[i].valid) chk($sformatf("tbl%0d_instr", i), a_instr, tbl[i].instr);
        end

        // Reset while the second instruction is presented, then restart from 0.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_pre_instr", a_instr, w0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_in_rd_en", a_rd_en, 0);
        chk("rst_in_valid", a_valid, 0);
        chk("rst_in_busy", a_busy, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_after_valid", a_valid, 0);
        chk("rst_after_busy", a_busy, 0);
        chk("rst_after_addr", a_addr, 0);
        chk("rst_after_rd_en", a_rd_en, 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("restart_rd_en", a_rd_en, 1);
        chk("restart_addr", a_addr, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("restart_valid", a_valid, 1);
        chk("restart_instr", a_instr, w0);

        // HALT at address 0.
        cyc(1'b1, 1'b0, 1'b0);
        mem_a[0] = mk(OP_HALT, 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("h0_rd_en", a_rd_en, 1);
        chk("h0_addr", a_addr, 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("h0_valid_halt", a_valid, 0);
        chk("h0_rd_gated", a_rd_en, 0);
        chk("h0_not_done_yet", a_done, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("h0_done", a_done, 1);
        chk("h0_overrun", a_overrun, 0);
        chk("h0_valid_done", a_valid, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("h0_done_once", a_done, 0);
        chk("h0_idle", a_busy, 0);

        // Overrun on the 8-word memory with no HALT.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        nvalid = 0; maxaddr = 0; ndone = 0; ovr_at_done = 1'b0;
        for (int c = 0; c < 40 && ndone == 0; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (b_valid) nvalid++;
            if (b_rd_en && int'(b_addr) > maxaddr) maxaddr = int'(b_addr);
            if (b_done) begin
                ndone++;
                ovr_at_done = b_overrun;
            end
        end
        chk("ovr_valid_count", nvalid, 8);
        chk("ovr_max_addr", maxaddr, 7);
        chk("ovr_done_seen", ndone, 1);
        chk("ovr_flag", ovr_at_done, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", b_overrun, 1);
        chk("ovr_idle_addr", b_addr, 7);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovr_cleared", b_overrun, 0);
        chk("ovr_restart_addr", b_addr, 0);

        // Random programs with random stalls on the full-size instance.
        cyc(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 16; r++) begin
            if (r % 5 == 0) rand_run(256);
            else if (r % 2 == 0) rand_run($urandom_range(0, 255));
            else rand_run($urandom_range(0, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
